// File: rtl/spi_stream_dma_if.sv
// spi_stream_dma_if: RX stream sink plus AHB-Lite write-master signals for spi_stream_dma
interface spi_stream_dma_if #(parameter int W_ADDR = 32);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [W_ADDR-1:0] ahblm_haddr;
    logic [1:0]        ahblm_htrans;
    logic              ahblm_hwrite;
    logic [2:0]        ahblm_hsize;
    logic [2:0]        ahblm_hburst;
    logic              ahblm_hready;
    logic              ahblm_hresp;
    logic [31:0]       ahblm_hwdata;
    modport master (
        input  in_valid, in_data, ahblm_hready, ahblm_hresp,
        output in_ready, ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize, ahblm_hburst, ahblm_hwdata
    );
    modport slave (
        output in_valid, in_data, ahblm_hready, ahblm_hresp,
        input  in_ready, ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize, ahblm_hburst, ahblm_hwdata
    );
endinterface

// File: rtl/spi_stream_dma.sv
// spi_stream_dma: pops stream words and writes them to consecutive AHB-Lite word addresses
module spi_stream_dma #(
    parameter int W_ADDR  = 32,
    parameter int W_COUNT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [W_ADDR-1:0]  cfg_addr,
    input  logic [W_COUNT-1:0] cfg_count,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [W_COUNT-1:0] remaining,
    spi_stream_dma_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [W_ADDR-1:0] cur_addr, aph_addr;
    logic [31:0] aph_data, dph_data;
    logic aph_valid, dph_valid, zero_done;
    logic aph_acc, err_first, empty, pop;

    assign aph_acc   = aph_valid && bus.ahblm_hready;
    assign err_first = dph_valid && bus.ahblm_hresp && !bus.ahblm_hready;
    assign empty     = !aph_valid && !dph_valid;
    assign pop       = bus.in_ready && bus.in_valid;

    assign bus.ahblm_haddr  = aph_addr;
    assign bus.ahblm_hwdata = dph_data;
    assign bus.ahblm_hwrite = 1'b1;
    assign bus.ahblm_hsize  = 3'b010;
    assign bus.ahblm_hburst = 3'b000;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cfg_start && cfg_count != '0) state_nx = RUN;
            RUN:     if (err_first || remaining == '0 || cfg_abort) state_nx = DRAIN;
            DRAIN:   if (empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // An error response kills the pending NONSEQ in its first cycle, so htrans is gated here.
    always_comb begin
        busy             = state != IDLE;
        done             = zero_done || (state == DRAIN && empty);
        bus.in_ready     = state == RUN && remaining != '0 && !cfg_abort && !bus.ahblm_hresp &&
                           (!aph_valid || aph_acc);
        bus.ahblm_htrans = aph_valid && !err_first ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            err       <= 1'b0;
            zero_done <= 1'b0;
            aph_valid <= 1'b0;
            aph_addr  <= '0;
            aph_data  <= '0;
            dph_valid <= 1'b0;
            dph_data  <= '0;
        end else begin
            zero_done <= state == IDLE && cfg_start && cfg_count == '0;
            if (state == IDLE && cfg_start) begin
                cur_addr  <= {cfg_addr[W_ADDR-1:2], 2'b00};
                remaining <= cfg_count;
                err       <= 1'b0;
            end
            if (err_first) err <= 1'b1;
            if (pop) begin
                aph_addr  <= cur_addr;
                aph_data  <= bus.in_data;
                cur_addr  <= cur_addr + W_ADDR'(4);
                remaining <= remaining - W_COUNT'(1);
            end
            aph_valid <= !err_first && (pop || (aph_valid && !aph_acc));
            if (aph_acc) begin
                dph_valid <= 1'b1;
                dph_data  <= aph_data;
            end else if (bus.ahblm_hready) begin
                dph_valid <= 1'b0;
            end
        end
    end
endmodule
